mem_arbiter: RTL

Two-port arbiter that shares the CPU's single 16-bit word memory port (15-bit word address, one write-enable, one-cycle synchronous read latency) between two requesters: port 0 (CPU memory controller) and port 1 (DMA/peripheral master).

- Each granted access is a fixed four-state sequence with registered memory outputs.
- Read data is registered before return, so requesters never see raw `mem_out`.
- Sits between the requesters and the memory macro, replacing the direct CPU-to-memory connection.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port word memory (one-cycle synchronous read)
//            between two requesters. Each granted access runs a fixed
//            IDLE -> MEM -> WAIT -> ACK sequence with registered memory-side
//            outputs and registered read data.
// Config   : MEM_ARB_ROUND_ROBIN_EN defined   -> round-robin on ties
//            MEM_ARB_ROUND_ROBIN_EN undefined -> port 0 always wins ties
// Ports    : clk, rst            clock, synchronous active-high reset
//            pN_req/we/addr/wdata  request from port N (held until pN_ack)
//            pN_ack, pN_rdata      one-cycle completion pulse, read data
//            mem_we/addr/in        memory write enable, address, write data
//            mem_out               memory read data (valid one cycle later)
//            busy                  high whenever the FSM is not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t        state_q;
  logic          gnt_q;      // granted port index of the access in flight
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_in_q;
  logic [DW-1:0] rdata_q;
  logic          p0_ack_q;
  logic          p1_ack_q;
  logic          busy_q;
  logic          sel1_d;     // arbitration result: 1 selects port 1

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          last_q;     // port served most recently

  // On a tie the port that was not served last wins.
  always_comb begin
    sel1_d = p1_req && (!p0_req || !last_q);
  end
`else
  // Fixed priority: port 1 wins only when port 0 is not asking.
  always_comb begin
    sel1_d = p1_req && !p0_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
      rdata_q    <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;        // port 0 wins the first tie
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            // Latch the winner's fields straight into the memory-side
            // output registers so they are presented during MEM.
            gnt_q      <= sel1_d;
            mem_we_q   <= sel1_d ? p1_we    : p0_we;
            mem_addr_q <= sel1_d ? p1_addr  : p0_addr;
            mem_in_q   <= sel1_d ? p1_wdata : p0_wdata;
            busy_q     <= 1'b1;
            state_q    <= S_MEM;
          end
        end
        S_MEM: begin
          mem_we_q <= 1'b0;          // write strobe lasts exactly one cycle
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          rdata_q  <= mem_out;       // read data valid one cycle after MEM
          p0_ack_q <= !gnt_q;
          p1_ack_q <= gnt_q;
          state_q  <= S_ACK;
        end
        S_ACK: begin
          // Returning to IDLE without arbitrating keeps a still-high req
          // from being served twice.
          p0_ack_q <= 1'b0;
          p1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_q   <= gnt_q;
`endif
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_rdata = rdata_q;
  assign p1_rdata = rdata_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_in   = mem_in_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire
